// File: rtl/mdio_pkg.sv
// Shared constants and state encoding for the MDIO Clause 22 responder.
package mdio_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned PREAMBLE_LEN = 32;
  localparam int unsigned CNT_W        = 6;
  localparam int unsigned NREG         = 1 << ADDR_W;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  typedef enum logic [3:0] {
    IDLE,
    ST2,
    OP,
    PHYAD,
    REGAD,
    TA,
    RD_DATA,
    WR_DATA,
    SKIP
  } state_e;

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings MDC/MDIO into the clk domain and flags MDC edges.
module mdio_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc,
  input  logic mdio_i,
  output logic rise_c,
  output logic fall_c,
  output logic mdio_s
);

  logic [SYNC_STAGES-1:0] mdc_q;
  logic [SYNC_STAGES-1:0] mdio_q;
  logic                   mdc_hist;

  // Equal-depth synchronizer chains keep MDIO aligned with the MDC edge that samples it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdc_q    <= '0;
      mdio_q   <= '1;
      mdc_hist <= 1'b0;
    end else begin
      mdc_q    <= {mdc_q[SYNC_STAGES-2:0], mdc};
      mdio_q   <= {mdio_q[SYNC_STAGES-2:0], mdio_i};
      mdc_hist <= mdc_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = mdc_q[SYNC_STAGES-1] & ~mdc_hist;
  assign fall_c = ~mdc_q[SYNC_STAGES-1] & mdc_hist;
  assign mdio_s = mdio_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO station: frame decoder, 32x16 register file, read-back driver.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mdc,
  input  logic              mdio_i,
  output logic              mdio_o,
  output logic              mdio_oe,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              wr_vld,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  logic rise_c;
  logic fall_c;
  logic mdio_s;

  mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .mdc    (mdc),
    .mdio_i (mdio_i),
    .rise_c (rise_c),
    .fall_c (fall_c),
    .mdio_s (mdio_s)
  );

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_first;
  logic              is_rd;
  logic              hit;
  logic [ADDR_W-1:0] phyad;
  logic [ADDR_W-1:0] regad;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] regs [NREG];

  logic [ADDR_W-1:0] regad_nxt_c;
  logic [DATA_W-1:0] shin_c;
  logic [1:0]        op_c;
  logic              mdio_we_c;

  assign regad_nxt_c = {regad[ADDR_W-2:0], mdio_s};
  assign shin_c      = {shreg[DATA_W-2:0], mdio_s};
  assign op_c        = {op_first, mdio_s};
  assign mdio_we_c   = (state == WR_DATA) && rise_c && (cnt == CNT_W'(DATA_W - 1));

  // Register file; an MDIO write overrides a local write to the same address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (loc_we)    regs[loc_addr] <= loc_wdata;
      if (mdio_we_c) regs[regad]    <= shin_c;
    end
  end

  // Frame FSM: bits sampled on MDC rise, read data launched on MDC fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_first <= 1'b0;
      is_rd    <= 1'b0;
      hit      <= 1'b0;
      phyad    <= '0;
      regad    <= '0;
      shreg    <= '0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
      wr_vld   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
    end else begin
      wr_vld <= 1'b0;
      case (state)
        IDLE: if (rise_c) begin
          if (mdio_s) begin
            if (cnt != CNT_W'(PREAMBLE_LEN)) cnt <= cnt + CNT_W'(1);
          end else if (cnt == CNT_W'(PREAMBLE_LEN)) begin
            state <= ST2;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        ST2: if (rise_c) begin
          cnt <= '0;
          if (mdio_s) state <= OP;
          else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        OP: if (rise_c) begin
          if (cnt == '0) begin
            op_first <= mdio_s;
            cnt      <= CNT_W'(1);
          end else begin
            cnt <= '0;
            if (op_c == OP_RD || op_c == OP_WR) begin
              state <= PHYAD;
              is_rd <= (op_c == OP_RD);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        PHYAD: if (rise_c) begin
          phyad <= {phyad[ADDR_W-2:0], mdio_s};
          if (cnt == CNT_W'(ADDR_W - 1)) begin
            state <= REGAD;
            cnt   <= '0;
          end else cnt <= cnt + CNT_W'(1);
        end
        REGAD: if (rise_c) begin
          regad <= regad_nxt_c;
          if (cnt == CNT_W'(ADDR_W - 1)) begin
            state <= TA;
            cnt   <= '0;
            hit   <= (phyad == PHY_ADDR);
            if (is_rd && (phyad == PHY_ADDR)) shreg <= regs[regad_nxt_c];
          end else cnt <= cnt + CNT_W'(1);
        end
        TA: begin
          if (!hit) begin
            // Another station's frame: ride out TA plus 16 data bits.
            state <= SKIP;
            cnt   <= '0;
          end else if (is_rd) begin
            if (rise_c) cnt <= CNT_W'(1);
            else if (fall_c && cnt == CNT_W'(1)) begin
              mdio_oe <= 1'b1;
              mdio_o  <= 1'b0;
              state   <= RD_DATA;
              cnt     <= '0;
            end
          end else if (rise_c) begin
            if (cnt == '0 && mdio_s) cnt <= CNT_W'(1);
            else if (cnt == CNT_W'(1) && !mdio_s) begin
              state <= WR_DATA;
              cnt   <= '0;
            end else begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end
        end
        RD_DATA: if (fall_c) begin
          if (cnt == CNT_W'(DATA_W)) begin
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
          end else begin
            mdio_o <= shreg[DATA_W-1];
            shreg  <= {shreg[DATA_W-2:0], 1'b0};
            cnt    <= cnt + CNT_W'(1);
          end
        end
        WR_DATA: if (rise_c) begin
          shreg <= shin_c;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            wr_vld  <= 1'b1;
            wr_addr <= regad;
            wr_data <= shin_c;
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
          end else cnt <= cnt + CNT_W'(1);
        end
        SKIP: if (rise_c) begin
          if (cnt == CNT_W'(DATA_W + 1)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else cnt <= cnt + CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
